// File: rtl/des_pkg.sv
// des_pkg
//   Shared DES key-schedule definitions: PC-1 / PC-2 permutation tables,
//   the per-round left-shift schedule, permutation helpers and 28-bit
//   rotators. Used by the sequential key scheduler and the DES round core.
//   Bit numbering follows FIPS 46-3: table entry n refers to DES bit n,
//   where bit 1 is the MSB of the vector.
package des_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ks_state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] des_pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = key[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // Shift amount for 1-based round r; rounds outside 1..16 do not rotate.
  function automatic logic [1:0] shift_amt(input int r);
    if (r >= 1 && r <= 16) return 2'(SHIFT_SCHED[r]);
    return 2'd0;
  endfunction

endpackage

// File: rtl/des_key_sched_seq_if.sv
// des_key_sched_seq_if
//   Request and subkey-stream handshake bundle for des_key_sched_seq.
//   master: key producer / subkey consumer side.  slave: the scheduler.
//   req_*  : key bundle request (valid/ready)
//   sk_*   : subkey stream (valid/ready), round index, last flag
//   busy   : schedule in progress
interface des_key_sched_seq_if #(
  parameter int NUM_KEYS = 1
);
  localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [64*NUM_KEYS-1:0] req_key;
  logic [SEL_W-1:0]      req_sel;
  logic                  req_dec;
  logic                  sk_valid;
  logic                  sk_ready;
  logic [47:0]           sk_data;
  logic [3:0]            sk_round;
  logic                  sk_last;
  logic                  busy;

  modport master (
    output req_valid, req_key, req_sel, req_dec, sk_ready,
    input  req_ready, sk_valid, sk_data, sk_round, sk_last, busy
  );

  modport slave (
    input  req_valid, req_key, req_sel, req_dec, sk_ready,
    output req_ready, sk_valid, sk_data, sk_round, sk_last, busy
  );

endinterface

// File: rtl/des_cd_step.sv
// des_cd_step
//   Combinational next-CD generator. Given the CD register for the beat
//   currently on the output (i_round, 0-based), returns the CD for the
//   following beat. Encrypt rotates each half left, decrypt rotates right.
//   i_cd    : current {C, D}
//   i_dec   : 1 = decrypt order
//   i_round : beat index currently presented
//   o_cd    : {C, D} for beat i_round+1
module des_cd_step
  import des_pkg::*;
(
  input  logic [55:0] i_cd,
  input  logic        i_dec,
  input  logic [3:0]  i_round,
  output logic [55:0] o_cd
);

  logic [1:0] w_amt;

  // Next beat is 1-based round r = i_round + 2. Decrypt walks the schedule
  // backwards, undoing the shift of round 18 - r, i.e. 16 - i_round.
  always_comb begin
    if (i_dec) w_amt = shift_amt(16 - int'(i_round));
    else       w_amt = shift_amt(int'(i_round) + 2);
  end

  always_comb begin
    if (i_dec) o_cd = {rotr28(i_cd[55:28], w_amt), rotr28(i_cd[27:0], w_amt)};
    else       o_cd = {rotl28(i_cd[55:28], w_amt), rotl28(i_cd[27:0], w_amt)};
  end

endmodule

// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq
//   Sequential DES/3DES key scheduler. Accepts one key bundle, then streams
//   the 16 PC-2 subkeys in encrypt (K1..K16) or decrypt (K16..K1) order,
//   one per accepted beat.
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   if_ks  : request / subkey handshake bundle (slave side)
//
//   state  | meaning
//   S_IDLE | req_ready high, waiting for a key request
//   S_RUN  | sk_valid high, streaming subkeys, round counter advancing
module des_key_sched_seq
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  des_key_sched_seq_if.slave    if_ks
);

  ks_state_t   r_state, w_state_nxt;
  logic [55:0] r_cd, w_cd_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic        r_dec, w_dec_nxt;

  logic [63:0] w_key;
  logic [55:0] w_cd0;
  logic [55:0] w_cd_load;
  logic [55:0] w_cd_step;

  // Out-of-range selects fall back to key 0.
  always_comb begin
    w_key = if_ks.req_key[63:0];
    for (int k = 1; k < NUM_KEYS; k++)
      if (int'(if_ks.req_sel) == k) w_key = if_ks.req_key[64*k +: 64];
  end

  // Decrypt starts from C0D0, which equals CD16 after the full 28-bit rotation.
  always_comb begin
    w_cd0 = des_pc1(w_key);
    if (if_ks.req_dec) w_cd_load = w_cd0;
    else               w_cd_load = {rotl28(w_cd0[55:28], 2'd1), rotl28(w_cd0[27:0], 2'd1)};
  end

  des_cd_step u_cd_step (
    .i_cd    (r_cd),
    .i_dec   (r_dec),
    .i_round (r_round),
    .o_cd    (w_cd_step)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cd    <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_round <= w_round_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_round_nxt = r_round;
    w_dec_nxt   = r_dec;
    unique case (r_state)
      S_IDLE: begin
        if (if_ks.req_valid) begin
          w_dec_nxt   = if_ks.req_dec;
          w_cd_nxt    = w_cd_load;
          w_round_nxt = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (if_ks.sk_ready) begin
          if (r_round == 4'd15) begin
            w_round_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_cd_nxt    = w_cd_step;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign if_ks.req_ready = (r_state == S_IDLE);
  assign if_ks.sk_valid  = (r_state == S_RUN);
  assign if_ks.busy      = (r_state == S_RUN);
  assign if_ks.sk_last   = (r_state == S_RUN) && (r_round == 4'd15);
  assign if_ks.sk_round  = r_round;
  assign if_ks.sk_data   = des_pc2(r_cd);

endmodule
